// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared external memory bus types and widths
package mem_bus_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int BUS_DATA_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    RDONE = 3'd2,
    WRITE = 3'd3,
    WREC  = 3'd4
  } sram_state_t;

endpackage

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - bus responder turning word reads/writes into timed async SRAM strobes
module sram_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic                  re_i,
  input  logic                  we_i,
  inout  wire  [BUS_DATA_W-1:0] data_io,
  output logic                  needWait_o,
  output logic [ADDR_W-1:0]     sram_addr_o,
  inout  wire  [BUS_DATA_W-1:0] sram_dq_io,
  output logic                  sram_ce_n_o,
  output logic                  sram_oe_n_o,
  output logic                  sram_we_n_o,
  output logic                  sram_ub_n_o,
  output logic                  sram_lb_n_o
);

  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);

  sram_state_t           state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_W-1:0]     addr_q;
  logic [BUS_DATA_W-1:0] wdata;
  logic [BUS_DATA_W-1:0] rdata;
  logic                  bus_oe;
  logic                  dq_oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      wdata  <= '0;
      rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // read wins when both requests are present; no write strobe is issued
          if (re_i) begin
            state  <= READ;
            cnt    <= RD_LOAD;
            addr_q <= addr_i;
          end else if (we_i) begin
            state  <= WRITE;
            cnt    <= WR_LOAD;
            addr_q <= addr_i;
            wdata  <= data_io;
          end
        end
        READ: begin
          if (cnt == '0) begin
            rdata <= sram_dq_io;
            state <= RDONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RDONE: state <= IDLE;
        WRITE: begin
          if (cnt == '0) begin
            state <= WREC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WREC:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an asynchronous reset releases them at once.
  always_comb begin
    sram_ce_n_o = 1'b1;
    sram_oe_n_o = 1'b1;
    sram_we_n_o = 1'b1;
    sram_ub_n_o = 1'b1;
    sram_lb_n_o = 1'b1;
    needWait_o  = 1'b0;
    bus_oe      = 1'b0;
    dq_oe       = 1'b0;
    case (state)
      IDLE: needWait_o = rst_n & (re_i | we_i);
      READ: begin
        sram_ce_n_o = 1'b0;
        sram_oe_n_o = 1'b0;
        sram_ub_n_o = 1'b0;
        sram_lb_n_o = 1'b0;
        needWait_o  = 1'b1;
      end
      RDONE: bus_oe = re_i;
      WRITE: begin
        sram_ce_n_o = 1'b0;
        sram_we_n_o = 1'b0;
        sram_ub_n_o = 1'b0;
        sram_lb_n_o = 1'b0;
        needWait_o  = 1'b1;
        dq_oe       = 1'b1;
      end
      WREC: begin
        // data and address stay put one cycle past the we_n rising edge for hold time
        sram_ce_n_o = 1'b0;
        sram_ub_n_o = 1'b0;
        sram_lb_n_o = 1'b0;
        dq_oe       = 1'b1;
      end
      default: needWait_o = 1'b0;
    endcase
  end

  assign sram_addr_o = addr_q;
  assign data_io     = bus_oe ? rdata : {BUS_DATA_W{1'bz}};
  assign sram_dq_io  = dq_oe  ? wdata : {BUS_DATA_W{1'bz}};

endmodule
